// File: rtl/counter_mod_pkg.sv
// Shared direction encoding and load clamp for counter_mod.
package counter_mod_pkg;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    function automatic int unsigned clamp_load(input int unsigned val, input int unsigned modulus);
        return (val < modulus) ? val : modulus - 1;
    endfunction

endpackage

// File: rtl/counter_mod.sv
// Modulo-MODULUS up/down counter with sync clear/load and cascadable carry/borrow.
// Optional sticky wrap flag enabled by defining COUNTER_MOD_STICKY_OVF_EN.
module counter_mod
    import counter_mod_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclr,
    input  logic             en,
    input  logic             clkEn,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             co,
    output logic             ovf,
    input  logic             clr_ovf
);

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

    generate
        if (WIDTH < 1 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_params
            $error("counter_mod: illegal WIDTH/MODULUS combination");
        end
    endgenerate

    logic             advance;
    logic [WIDTH-1:0] count_nxt;

    assign advance = en & clkEn;
    assign tc      = ((dir == DIR_UP) && (count == MAX_CNT)) || ((dir == DIR_DOWN) && (count == '0));
    assign co      = tc & advance;

    always_comb begin
        count_nxt = count;
        if (sclr) begin
            count_nxt = '0;
        end else if (load) begin
            count_nxt = WIDTH'(clamp_load(32'(load_val), MODULUS));
        end else if (advance) begin
            if (dir == DIR_UP) begin
                count_nxt = (count == MAX_CNT) ? '0 : count + 1'b1;
            end else begin
                count_nxt = (count == '0) ? MAX_CNT : count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

`ifdef COUNTER_MOD_STICKY_OVF_EN
    // A wrap only happens when the advance actually takes the edge (sclr/load pre-empt it).
    logic wrap;
    assign wrap = co & ~sclr & ~load;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (wrap) begin
            ovf <= 1'b1;
        end else if (clr_ovf || sclr) begin
            ovf <= 1'b0;
        end
    end
`else
    logic unused_clr_ovf;
    assign unused_clr_ovf = clr_ovf;
    assign ovf            = 1'b0;
`endif

endmodule

// File: tb/tb_counter_mod.sv
// Scoreboard bench for counter_mod: main unit (M10), two-stage cascade (M10), sticky unit (M16).
module tb_counter_mod;

    typedef struct {
        int         unit;
        string      name;
        logic [3:0] cnt;
        logic       tc;
        logic       co;
        logic       chk_ovf;
        logic       ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // main unit
    logic       m_sclr = 0, m_en = 0, m_clk_en = 0, m_dir = 0, m_load = 0, m_clr_ovf = 0;
    logic [3:0] m_load_val = '0;
    logic [3:0] m_count;
    logic       m_tc, m_co, m_ovf;

    // cascade
    logic       cas_en = 0;
    logic [3:0] c0_count, c1_count;
    logic       c0_tc, c0_co, c0_ovf, c1_tc, c1_co, c1_ovf;

    // sticky / full-binary unit
    logic       s_en = 0, s_clr_ovf = 0;
    logic [3:0] s_count;
    logic       s_tc, s_co, s_ovf;

    counter_mod #(.WIDTH(4), .MODULUS(10)) u_main (
        .clk(clk), .rst(rst), .sclr(m_sclr), .en(m_en), .clkEn(m_clk_en), .dir(m_dir),
        .load(m_load), .load_val(m_load_val), .count(m_count), .tc(m_tc), .co(m_co),
        .ovf(m_ovf), .clr_ovf(m_clr_ovf)
    );

    counter_mod #(.WIDTH(4), .MODULUS(10)) u_cas0 (
        .clk(clk), .rst(rst), .sclr(1'b0), .en(cas_en), .clkEn(1'b1), .dir(1'b0),
        .load(1'b0), .load_val(4'd0), .count(c0_count), .tc(c0_tc), .co(c0_co),
        .ovf(c0_ovf), .clr_ovf(1'b0)
    );

    counter_mod #(.WIDTH(4), .MODULUS(10)) u_cas1 (
        .clk(clk), .rst(rst), .sclr(1'b0), .en(cas_en), .clkEn(c0_co), .dir(1'b0),
        .load(1'b0), .load_val(4'd0), .count(c1_count), .tc(c1_tc), .co(c1_co),
        .ovf(c1_ovf), .clr_ovf(1'b0)
    );

    counter_mod #(.WIDTH(4), .MODULUS(16)) u_sticky (
        .clk(clk), .rst(rst), .sclr(1'b0), .en(s_en), .clkEn(1'b1), .dir(1'b0),
        .load(1'b0), .load_val(4'd0), .count(s_count), .tc(s_tc), .co(s_co),
        .ovf(s_ovf), .clr_ovf(s_clr_ovf)
    );

`ifdef COUNTER_MOD_STICKY_OVF_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    event mid_ev;

    task automatic push_exp(input int unit, input string name, input logic [3:0] c,
                            input logic t, input logic o, input logic chk_ovf, input logic v);
        exp_t e;
        e.unit = unit; e.name = name; e.cnt = c; e.tc = t; e.co = o;
        e.chk_ovf = chk_ovf; e.ovf = v;
        sb.push_back(e);
    endtask

    // Monitor: sample 2 time units after each rising edge (or after a mid-cycle event).
    initial begin
        exp_t       e;
        logic [3:0] ac;
        logic       at, ao, av;
        forever begin
            @(posedge clk or mid_ev);
            #2;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.unit)
                    0:       begin ac = m_count;  at = m_tc;  ao = m_co;  av = m_ovf;  end
                    1:       begin ac = c0_count; at = c0_tc; ao = c0_co; av = c0_ovf; end
                    2:       begin ac = c1_count; at = c1_tc; ao = c1_co; av = c1_ovf; end
                    default: begin ac = s_count;  at = s_tc;  ao = s_co;  av = s_ovf;  end
                endcase
                total++;
                if (ac !== e.cnt || at !== e.tc || ao !== e.co || (e.chk_ovf && av !== e.ovf)) begin
                    bad++;
                    $display("FAIL %s: got count=%0d tc=%b co=%b ovf=%b, want count=%0d tc=%b co=%b ovf=%b%s",
                             e.name, ac, at, ao, av, e.cnt, e.tc, e.co, e.ovf,
                             e.chk_ovf ? "" : " (ovf not checked)");
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] k0, k1;

        // reset held: enables high, clock running, count stays 0
        m_en = 1; m_clk_en = 1; m_dir = 0;
        repeat (3) begin
            @(posedge clk);
            push_exp(0, "reset_hold", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            push_exp(3, "reset_hold_s", 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        end

        // release and count up through a full wrap
        @(negedge clk); rst = 1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            k0 = 4'(k % 10);
            push_exp(0, "up_count", k0, k0 == 4'd9, k0 == 4'd9, 1'b0, 1'b0);
        end
        repeat (2) begin
            @(posedge clk);
        end
        @(negedge clk);
        push_exp(0, "at_two", 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        ->mid_ev;

        // count down from 2: 1, 0, hold (clkEn low), 9, 8
        m_dir = 1;
        @(posedge clk); push_exp(0, "down_1", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); push_exp(0, "down_0", 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk); m_clk_en = 0;
        @(posedge clk); push_exp(0, "down_hold_tc", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk); m_clk_en = 1;
        @(posedge clk); push_exp(0, "down_wrap9", 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); push_exp(0, "down_8", 4'd8, 1'b0, 1'b0, 1'b0, 1'b0);

        // loads: clamp, boundary, and load beating an enabled advance (co still driven)
        @(negedge clk); m_dir = 0; m_load = 1; m_load_val = 4'd12;
        @(posedge clk); push_exp(0, "load_clamp12", 4'd9, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk); m_load_val = 4'd5;
        @(posedge clk); push_exp(0, "load_wins5", 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); m_load_val = 4'd10; m_en = 0;
        @(posedge clk); push_exp(0, "load_clamp10", 4'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk); m_load_val = 4'd7;
        @(posedge clk); push_exp(0, "load_7", 4'd7, 1'b0, 1'b0, 1'b0, 1'b0);

        // sclr beats load
        @(negedge clk); m_sclr = 1; m_load_val = 4'd3; m_en = 1;
        @(posedge clk); push_exp(0, "sclr_over_load", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); m_sclr = 0; m_load_val = 4'd7; m_en = 0;
        @(posedge clk); push_exp(0, "reload_7", 4'd7, 1'b0, 1'b0, 1'b0, 1'b0);

        // asynchronous reset mid-cycle
        @(negedge clk); m_load = 0;
        #1 rst = 0;
        push_exp(0, "async_rst", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        ->mid_ev;
        @(negedge clk); rst = 1;
        @(posedge clk); push_exp(0, "release_no_en", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // two-stage cascade, 100 enabled edges
        @(negedge clk); cas_en = 1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            k0 = 4'(k % 10);
            k1 = 4'((k / 10) % 10);
            push_exp(1, "cas_stage0", k0, k0 == 4'd9, k0 == 4'd9, 1'b0, 1'b0);
            push_exp(2, "cas_stage1", k1, k1 == 4'd9, (k1 == 4'd9) && (k0 == 4'd9), 1'b0, 1'b0);
        end
        @(negedge clk); cas_en = 0;

        // full-binary modulus and sticky wrap flag
        s_en = 1;
        for (int k = 1; k <= 19; k++) begin
            @(posedge clk);
            k0 = 4'(k % 16);
            push_exp(3, "sticky_run", k0, k0 == 4'd15, k0 == 4'd15, 1'b1, STICKY && (k >= 16));
        end
        @(negedge clk); s_en = 0; s_clr_ovf = 1;
        @(posedge clk); push_exp(3, "sticky_clr", 4'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk); s_clr_ovf = 0;
        @(posedge clk); push_exp(3, "sticky_after_clr", 4'd3, 1'b0, 1'b0, 1'b1, 1'b0);

        @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
